// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone B4 classic arbiter with bus-timeout watchdog
module wb_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic        busy_o,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  GNT   = 2'd1;
    localparam logic [1:0]  TERR  = 2'd2;
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d, grant_q, grant_d, rel;
    logic        last_q, last_d, g0, g1, terr, own_cyc, stall;
    logic [15:0] cnt_q, cnt_d;

    // One-hot winner among requesters; last=1 means m1 was granted last
    function automatic logic [1:0] pick(input logic r0, input logic r1, input logic last);
        pick = (r0 && r1) ? ((FIXED_PRIO || last) ? 2'b01 : 2'b10) : {r1, r0};
    endfunction

    assign g0      = state_q == GNT && grant_q[0];
    assign g1      = state_q == GNT && grant_q[1];
    assign terr    = state_q == TERR;
    assign own_cyc = |(grant_q & {m1_cyc_i, m0_cyc_i});
    assign rel     = pick(grant_q[1] & m0_cyc_i, grant_q[0] & m1_cyc_i, last_q);
    assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;

    // Next grant/state: arbitrate from IDLE, hand over on release, watchdog into TERR
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (state_q == IDLE) begin
            grant_d = pick(m0_cyc_i, m1_cyc_i, last_q);
            state_d = |grant_d ? GNT : IDLE;
        end else if (!own_cyc) begin
            grant_d = rel;
            state_d = |rel ? GNT : IDLE;
        end else begin
            state_d = (state_q == GNT && stall && cnt_q == LIMIT) ? TERR : GNT;
        end
        last_d = |grant_d ? grant_d[1] : last_q;
        cnt_d  = (state_q == GNT && state_d == GNT && grant_d == grant_q && stall)
                 ? ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1) : 16'd0;
    end

    // Only grant, state, last winner and watchdog count are registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_adr_o   = g0 ? m0_adr_i : g1 ? m1_adr_i : 32'd0;
    assign s_dat_o   = g0 ? m0_dat_i : g1 ? m1_dat_i : 32'd0;
    assign s_sel_o   = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'd0;
    assign s_we_o    = (g0 & m0_we_i) | (g1 & m1_we_i);
    assign s_cyc_o   = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign s_stb_o   = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    assign m0_dat_o  = g0 ? s_dat_i : 32'd0;
    assign m1_dat_o  = g1 ? s_dat_i : 32'd0;
    assign m0_ack_o  = g0 & s_ack_i;
    assign m1_ack_o  = g1 & s_ack_i;
    assign m0_err_o  = (g0 & s_err_i) | (terr & grant_q[0]);
    assign m1_err_o  = (g1 & s_err_i) | (terr & grant_q[1]);
    assign busy_o    = |grant_q;
    assign grant_o   = grant_q;
    assign timeout_o = terr;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed checks of arbitration, block cycles, watchdog and reset
module tb_wb_arbiter_2m;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o, busy_o, timeout_o;
    logic [1:0]  grant_o;
    logic [31:0] f_m0_dat_o, f_m1_dat_o, f_s_adr_o, f_s_dat_o;
    logic [3:0]  f_s_sel_o;
    logic        f_m0_ack_o, f_m0_err_o, f_m1_ack_o, f_m1_err_o, f_s_we_o, f_s_cyc_o, f_s_stb_o, f_busy_o, f_timeout_o;
    logic [1:0]  f_grant_o;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wb_arbiter_2m #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(f_m0_dat_o), .m0_ack_o(f_m0_ack_o), .m0_err_o(f_m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(f_m1_dat_o), .m1_ack_o(f_m1_ack_o), .m1_err_o(f_m1_err_o),
        .s_adr_o(f_s_adr_o), .s_dat_o(f_s_dat_o), .s_sel_o(f_s_sel_o), .s_we_o(f_s_we_o),
        .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .busy_o(f_busy_o), .grant_o(f_grant_o), .timeout_o(f_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        {m0_adr, m0_dat, m1_adr, m1_dat, s_dat} = '0;
        {m0_sel, m1_sel} = '0;
        {m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err} = '0;
        nxt(); nxt(); #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_busy", busy_o, 0);
        chk("rst_scyc", {s_cyc_o, s_stb_o, timeout_o}, 0);
        chk("rst_m0", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
        nxt(); reset_n = 1'b1;
        // tie A straight after reset: m0 wins, m1 follows without an idle bubble
        m0_cyc = 1; m1_cyc = 1;
        nxt(); #1;
        chk("tieA_rr", grant_o, 2'b01);
        chk("tieA_fp", f_grant_o, 2'b01);
        m0_cyc = 0;
        nxt(); #1;
        chk("handover_rr", grant_o, 2'b10);
        chk("handover_busy", busy_o, 1);
        chk("handover_fp", f_grant_o, 2'b10);
        m1_cyc = 0;
        nxt(); #1;
        chk("idle_after_A", grant_o, 2'b00);
        m0_cyc = 1; m1_cyc = 1;
        nxt(); #1;
        chk("tieB_rr", grant_o, 2'b01);
        chk("tieB_fp", f_grant_o, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        nxt();
        m0_cyc = 1; m1_cyc = 1;
        nxt(); #1;
        chk("tieC_rr", grant_o, 2'b10);
        chk("tieC_fp", f_grant_o, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        nxt();
        // m0 single read, ack two cycles after strobe
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100; m0_sel = 4'hF;
        #1;
        chk("rd_pre_cyc", s_cyc_o, 0);
        nxt(); #1;
        chk("rd_cyc", s_cyc_o, 1);
        chk("rd_adr", s_adr_o, 32'h0000_0100);
        chk("rd_sel", s_sel_o, 4'hF);
        chk("rd_grant", grant_o, 2'b01);
        nxt(); #1;
        chk("rd_wait", m0_ack_o, 0);
        nxt(); s_ack = 1; s_dat = 32'hDEAD_BEEF; #1;
        chk("rd_ack", m0_ack_o, 1);
        chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_m1_ack", {m1_ack_o, m1_dat_o}, 0);
        nxt(); s_ack = 0; s_dat = 0; m0_cyc = 0; m0_stb = 0; #1;
        chk("rd_rel_cyc", s_cyc_o, 0);
        nxt(); #1;
        chk("rd_idle", {busy_o, grant_o}, 0);
        // m1 locked block write while m0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0200; m1_dat = 32'h1234_5678;
        nxt(); #1;
        chk("blk_grant", grant_o, 2'b10);
        chk("blk_we", s_we_o, 1);
        chk("blk_dat", s_dat_o, 32'h1234_5678);
        m0_cyc = 1;
        for (int i = 0; i < 4; i++) begin
            nxt(); s_ack = 1; #1;
            chk("blk_hold", grant_o, 2'b10);
            chk("blk_m1_ack", m1_ack_o, 1);
            chk("blk_m0_ack", m0_ack_o, 0);
        end
        nxt(); s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; #1;
        chk("blk_rel_grant", grant_o, 2'b10);
        nxt(); #1;
        chk("blk_m0_grant", grant_o, 2'b01);
        m0_cyc = 0;
        nxt();
        // watchdog: no ack for 8 strobe cycles
        m0_cyc = 1; m0_stb = 1;
        nxt(); #1;
        for (int k = 0; k < 8; k++) begin
            chk("to_quiet", {m0_err_o, timeout_o}, 0);
            nxt(); #1;
        end
        chk("to_err", m0_err_o, 1);
        chk("to_pulse", timeout_o, 1);
        chk("to_forced", {s_cyc_o, s_stb_o}, 0);
        chk("to_grant", grant_o, 2'b01);
        chk("to_m1_err", m1_err_o, 0);
        nxt(); #1;
        chk("to_once", {m0_err_o, timeout_o}, 0);
        chk("to_resume", s_stb_o, 1);
        m0_cyc = 0; m0_stb = 0;
        nxt();
        // ack at the last allowed cycle beats the watchdog
        m0_cyc = 1; m0_stb = 1;
        nxt();
        for (int k = 0; k < 7; k++) nxt();
        s_ack = 1; #1;
        chk("late_ack", m0_ack_o, 1);
        chk("late_noerr", {m0_err_o, timeout_o}, 0);
        nxt(); s_ack = 0; #1;
        chk("late_after", {m0_err_o, timeout_o}, 0);
        chk("late_stb", s_stb_o, 1);
        m0_cyc = 0; m0_stb = 0;
        nxt();
        // asynchronous reset in the middle of an m1 transfer
        m1_cyc = 1; m1_stb = 1;
        nxt(); #1;
        chk("rst_mid_grant", grant_o, 2'b10);
        s_ack = 1; #1;
        chk("rst_mid_ack", m1_ack_o, 1);
        reset_n = 0; #1;
        chk("rst_mid_cyc", s_cyc_o, 0);
        chk("rst_mid_g", grant_o, 2'b00);
        chk("rst_mid_ack0", {m1_ack_o, m1_err_o, busy_o}, 0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        nxt(); reset_n = 1; m0_cyc = 1; m1_cyc = 1;
        nxt(); #1;
        chk("rst_tie", grant_o, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master Wishbone B4 classic arbiter with a bus-timeout watchdog.
- Shares the single SoC Wishbone interconnect port between the core data master (m0, from wishbone_controller) and a second master (m1, boot loader / DMA).
- Sits between the masters and wb_intercon. Grants one master per bus cycle. Returns an error to the granted master if no slave acknowledges within a bounded time.

Parameters:
- TIMEOUT_CYCLES, 255, cycles of s_stb high with no s_ack before an error is returned (legal range 2..65535)
- FIXED_PRIO, 0, 0 = round-robin on contention; 1 = m0 always wins contention

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_adr_i  in  32  master 0 address
- m0_dat_i  in  32  master 0 write data
- m0_sel_i  in  4  master 0 byte select
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle / bus request
- m0_stb_i  in  1  master 0 strobe
- m0_dat_o  out  32  read data to master 0
- m0_ack_o  out  1  acknowledge to master 0
- m0_err_o  out  1  error to master 0
- m1_* (adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, dat_o, ack_o, err_o): same widths and meaning, master 1
- s_adr_o  out  32  address to interconnect
- s_dat_o  out  32  write data to interconnect
- s_sel_o  out  4  byte select to interconnect
- s_we_o  out  1  write enable to interconnect
- s_cyc_o  out  1  cycle to interconnect
- s_stb_o  out  1  strobe to interconnect
- s_dat_i  in  32  read data from interconnect
- s_ack_i  in  1  acknowledge from interconnect
- s_err_i  in  1  error from interconnect
- busy_o  out  1  a grant is active
- grant_o  out  2  one-hot current grant ({m1,m0})
- timeout_o  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset values, all asynchronous on reset_n low:
  - state = IDLE, grant_o = 00, busy_o = 0, timeout_o = 0.
  - All s_* outputs and all m*_ack/err/dat outputs are 0.
  - last_grant = m1, so m0 wins the first tie.
  - Watchdog counter = 0.
- States and transitions:
  - IDLE -> G0 or G1 on the clock edge after any mX_cyc_i is sampled high.
  - Only one master requesting: grant that master.
  - Both requesting: FIXED_PRIO=1 grants m0; FIXED_PRIO=0 grants the master that is not last_grant.
  - last_grant updates on every grant.
- Grant latency: 1 cycle from mX_cyc_i high to s_cyc_o high.
- GX (X = 0 or 1):
  - s_* outputs are combinational pass-through of mX_*.
  - mX_dat_o = s_dat_i, mX_ack_o = s_ack_i, mX_err_o = s_err_i.
  - The other master sees ack = 0, err = 0, dat = 0. Its request is held off.
  - Grant persists across back-to-back strobes while mX_cyc_i stays high (locked block cycles).
- Leaving GX when mX_cyc_i is sampled low:
  - Other master requesting: go directly to its grant (no IDLE bubble), using the same arbitration rule.
  - Otherwise: go to IDLE.
- s_cyc_o and s_stb_o are never high while grant_o = 00.
- Watchdog:
  - Counter increments each cycle s_stb_o = 1 and s_ack_i = 0 and s_err_i = 0.
  - Counter clears on s_ack_i, s_err_i, s_stb_o = 0, or a grant change.
  - Counter saturates; it never wraps.
- Timeout cycle, entered when the counter reaches TIMEOUT_CYCLES - 1 with no ack/err:
  - Next cycle is TERR: mX_err_o = 1, timeout_o = 1, s_cyc_o = s_stb_o = 0 (forced), s_ack_i ignored, counter cleared.
  - After TERR, return to GX if mX_cyc_i is still high, otherwise follow the release rule.
- An ack arriving in the same cycle the counter reaches its limit wins: normal ack, no error.
- Reset mid-cycle: grant is dropped immediately and outputs return to reset values. No ack or err is generated.
- The arbiter adds no pipeline registers on the data path. Only grant, state and counter are registered.

Test Plan:
- m0 single read, slave acks 2 cycles after stb with s_dat_i = 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses with m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 assert cyc in the same cycle after reset, FIXED_PRIO = 0 -> grant_o = 01 first. When m0 drops cyc, grant_o = 10 on the next edge with no IDLE cycle. The next tie goes to m0.
- FIXED_PRIO = 1, three successive ties -> m0 granted all three times. m1 is granted only when m0_cyc_i = 0.
- m1 holds cyc through 4 back-to-back write strobes while m0 requests -> grant_o stays 10 for all 4 acks. m0 is granted 1 cycle after m1_cyc_i falls.
- TIMEOUT_CYCLES = 8, slave never acks m0's stb -> m0_err_o and timeout_o pulse for exactly 1 cycle at stb + 8, with s_stb_o = 0 in that cycle. An ack at exactly stb + 7 instead gives ack with no err.
- reset_n pulsed low while G1 is mid-transfer -> s_cyc_o, grant_o and m1_ack_o go to 0 immediately. After release, the first tie grants m0.
